// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer-side result channels and the common data bus broadcast.
//   src_en / src_ROB_index / src_value / src_next_pc : per-source results, source k
//                                                      packed at [k*W +: W]
//   src_ready                                        : per-source buffer not full
//   CDB_en / CDB_ROB_index / CDB_value / CDB_next_pc / CDB_src : broadcast
//   master = producers and CDB consumers, slave = arbiter
interface cdb_arbiter_if #(
  parameter int unsigned ROB_WIDTH  = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned SRC_WIDTH  = 1
);
  logic [NUM_SRC-1:0]            src_en;
  logic [NUM_SRC*ROB_WIDTH-1:0]  src_ROB_index;
  logic [NUM_SRC*32-1:0]         src_value;
  logic [NUM_SRC*ADDR_WIDTH-1:0] src_next_pc;
  logic [NUM_SRC-1:0]            src_ready;
  logic                          CDB_en;
  logic [ROB_WIDTH-1:0]          CDB_ROB_index;
  logic [31:0]                   CDB_value;
  logic [ADDR_WIDTH-1:0]         CDB_next_pc;
  logic [SRC_WIDTH-1:0]          CDB_src;

  modport master (
    output src_en, src_ROB_index, src_value, src_next_pc,
    input  src_ready, CDB_en, CDB_ROB_index, CDB_value, CDB_next_pc, CDB_src
  );

  modport slave (
    input  src_en, src_ROB_index, src_value, src_next_pc,
    output src_ready, CDB_en, CDB_ROB_index, CDB_value, CDB_next_pc, CDB_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers results from NUM_SRC producers in per-source FIFOs and
// broadcasts at most one per cycle on the CDB, round-robin between sources.
//   clk_in   : clock, rising edge
//   rst_in   : asynchronous active-low reset
//   rdy_in   : global ready, 0 pauses enqueue, dequeue and arbitration
//   clear_in : synchronous flush of every buffer and the round-robin pointer
//   bus      : producer channels in, src_ready and CDB broadcast out
module cdb_arbiter #(
  parameter int unsigned ROB_WIDTH  = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SRC_WIDTH  = 1
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         clear_in,
  cdb_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = SRC_WIDTH + 1;
  localparam int unsigned VAL_W = 32;

  logic [CNT_W-1:0]      count_q   [NUM_SRC];
  logic [CNT_W-1:0]      count_d   [NUM_SRC];
  logic [PTR_W-1:0]      wr_ptr_q  [NUM_SRC];
  logic [PTR_W-1:0]      wr_ptr_d  [NUM_SRC];
  logic [PTR_W-1:0]      rd_ptr_q  [NUM_SRC];
  logic [PTR_W-1:0]      rd_ptr_d  [NUM_SRC];
  logic [ROB_WIDTH-1:0]  tag_mem_q [NUM_SRC][FIFO_DEPTH];
  logic [ROB_WIDTH-1:0]  tag_mem_d [NUM_SRC][FIFO_DEPTH];
  logic [VAL_W-1:0]      val_mem_q [NUM_SRC][FIFO_DEPTH];
  logic [VAL_W-1:0]      val_mem_d [NUM_SRC][FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_q  [NUM_SRC][FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_d  [NUM_SRC][FIFO_DEPTH];

  logic [SRC_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NUM_SRC-1:0]    src_ready_q, src_ready_d;
  logic                  cdb_en_q, cdb_en_d;
  logic [ROB_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;
  logic [VAL_W-1:0]      cdb_val_q, cdb_val_d;
  logic [ADDR_WIDTH-1:0] cdb_pc_q, cdb_pc_d;
  logic [SRC_WIDTH-1:0]  cdb_src_q, cdb_src_d;

  logic                  grant_vld_c;
  logic [SRC_WIDTH-1:0]  grant_idx_c;
  logic [NUM_SRC-1:0]    enq_c, deq_c;

  // First non-empty FIFO scanning upward from rr_ptr, wrapping at NUM_SRC.
  always_comb begin : rr_pick
    logic [SUM_W-1:0] cand;
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cand = SUM_W'(rr_ptr_q) + SUM_W'(i);
      if (cand >= SUM_W'(NUM_SRC)) cand = cand - SUM_W'(NUM_SRC);
      if (!grant_vld_c && (count_q[cand[SRC_WIDTH-1:0]] != '0)) begin
        grant_vld_c = 1'b1;
        grant_idx_c = cand[SRC_WIDTH-1:0];
      end
    end
  end

  // FIFO updates, broadcast load and round-robin advance.
  always_comb begin : next_state
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    tag_mem_d   = tag_mem_q;
    val_mem_d   = val_mem_q;
    pc_mem_d    = pc_mem_q;
    rr_ptr_d    = rr_ptr_q;
    cdb_en_d    = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_val_d   = cdb_val_q;
    cdb_pc_d    = cdb_pc_q;
    cdb_src_d   = cdb_src_q;
    enq_c       = '0;
    deq_c       = '0;
    src_ready_d = '1;

    if (clear_in) begin
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        count_d[k]  = '0;
        wr_ptr_d[k] = '0;
        rd_ptr_d[k] = '0;
      end
      rr_ptr_d = '0;
    end else if (rdy_in) begin
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        // Readiness comes from the registered count only, so a full FIFO
        // refuses input even on the cycle it is being dequeued.
        enq_c[k] = bus.src_en[k] & src_ready_q[k];
        deq_c[k] = grant_vld_c && (grant_idx_c == SRC_WIDTH'(k));
        if (enq_c[k]) begin
          tag_mem_d[k][wr_ptr_q[k]] = bus.src_ROB_index[k*ROB_WIDTH +: ROB_WIDTH];
          val_mem_d[k][wr_ptr_q[k]] = bus.src_value[k*VAL_W +: VAL_W];
          pc_mem_d[k][wr_ptr_q[k]]  = bus.src_next_pc[k*ADDR_WIDTH +: ADDR_WIDTH];
          wr_ptr_d[k] = wr_ptr_q[k] + PTR_W'(1);
        end
        if (deq_c[k]) rd_ptr_d[k] = rd_ptr_q[k] + PTR_W'(1);
        count_d[k] = count_q[k] + CNT_W'(enq_c[k]) - CNT_W'(deq_c[k]);
      end
      if (grant_vld_c) begin
        cdb_en_d  = 1'b1;
        cdb_tag_d = tag_mem_q[grant_idx_c][rd_ptr_q[grant_idx_c]];
        cdb_val_d = val_mem_q[grant_idx_c][rd_ptr_q[grant_idx_c]];
        cdb_pc_d  = pc_mem_q[grant_idx_c][rd_ptr_q[grant_idx_c]];
        cdb_src_d = grant_idx_c;
        rr_ptr_d  = (grant_idx_c == SRC_WIDTH'(NUM_SRC - 1)) ? '0
                                                             : grant_idx_c + SRC_WIDTH'(1);
      end
    end

    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      src_ready_d[k] = (count_d[k] < CNT_W'(FIFO_DEPTH));
    end
  end

  // Control and output registers.
  always_ff @(posedge clk_in or negedge rst_in) begin : ctrl_regs
    if (!rst_in) begin
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        count_q[k]  <= '0;
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
      end
      rr_ptr_q    <= '0;
      src_ready_q <= '1;
      cdb_en_q    <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_val_q   <= '0;
      cdb_pc_q    <= '0;
      cdb_src_q   <= '0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rr_ptr_q    <= rr_ptr_d;
      src_ready_q <= src_ready_d;
      cdb_en_q    <= cdb_en_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_val_q   <= cdb_val_d;
      cdb_pc_q    <= cdb_pc_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  // Payload storage; validity is tracked by the counts, so no reset needed.
  always_ff @(posedge clk_in) begin : storage
    tag_mem_q <= tag_mem_d;
    val_mem_q <= val_mem_d;
    pc_mem_q  <= pc_mem_d;
  end

  assign bus.src_ready     = src_ready_q;
  assign bus.CDB_en        = cdb_en_q;
  assign bus.CDB_ROB_index = cdb_tag_q;
  assign bus.CDB_value     = cdb_val_q;
  assign bus.CDB_next_pc   = cdb_pc_q;
  assign bus.CDB_src       = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for cdb_arbiter. A queue-per-source reference
// model predicts each broadcast and the cycle it must appear in; a monitor
// compares the CDB every cycle.
module tb_cdb_arbiter;
  localparam int unsigned RW    = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned NS    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SW    = 1;

  typedef struct packed {
    logic [SW-1:0] src;
    logic [RW-1:0] tag;
    logic [31:0]   val;
    logic [AW-1:0] pc;
    int            cyc;
  } entry_t;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic clear_in;

  cdb_arbiter_if #(.ROB_WIDTH(RW), .ADDR_WIDTH(AW), .NUM_SRC(NS), .SRC_WIDTH(SW)) bus ();

  cdb_arbiter #(
    .ROB_WIDTH(RW), .ADDR_WIDTH(AW), .NUM_SRC(NS), .FIFO_DEPTH(DEPTH), .SRC_WIDTH(SW)
  ) dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rdy_in  (rdy_in),
    .clear_in(clear_in),
    .bus     (bus)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int vectors = 0;
  int errors  = 0;

  entry_t        mq [NS][$];
  entry_t        exp_q[$];
  entry_t        last_exp = '0;
  int            rr = 0;
  logic [RW-1:0] d_tag [NS];
  logic [31:0]   d_val [NS];
  logic [AW-1:0] d_pc  [NS];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Reference: a buffered result leaves its queue on the first active edge where
  // round-robin selects it, and is seen on the CDB during the following cycle.
  task automatic model_step(input logic [NS-1:0] en, input logic rdy, input logic clr);
    int     pre [NS];
    entry_t e;
    if (clr) begin
      for (int k = 0; k < NS; k++) mq[k].delete();
      rr = 0;
    end else if (rdy) begin
      for (int k = 0; k < NS; k++) pre[k] = mq[k].size();
      for (int i = 0; i < NS; i++) begin
        int s;
        s = (rr + i) % NS;
        if (pre[s] > 0) begin
          e = mq[s].pop_front();
          e.cyc = cyc + 1;
          exp_q.push_back(e);
          rr = (s + 1) % NS;
          break;
        end
      end
      for (int k = 0; k < NS; k++) begin
        if (en[k] && pre[k] < DEPTH) begin
          e.src = SW'(k);
          e.tag = d_tag[k];
          e.val = d_val[k];
          e.pc  = d_pc[k];
          e.cyc = 0;
          mq[k].push_back(e);
        end
      end
    end
  endtask

  // One cycle: check readiness, drive inputs at the falling edge, advance model.
  task automatic step(input logic [NS-1:0] en, input logic rdy, input logic clr);
    @(negedge clk_in);
    for (int k = 0; k < NS; k++) begin
      logic want_rdy;
      want_rdy = (mq[k].size() < DEPTH);
      vectors++;
      if (bus.src_ready[k] !== want_rdy) begin
        errors++;
        $display("FAIL src_ready[%0d] cyc %0d got %b want %b", k, cyc, bus.src_ready[k], want_rdy);
      end
    end
    bus.src_en = en;
    rdy_in     = rdy;
    clear_in   = clr;
    for (int k = 0; k < NS; k++) begin
      bus.src_ROB_index[k*RW +: RW] = d_tag[k];
      bus.src_value[k*32 +: 32]     = d_val[k];
      bus.src_next_pc[k*AW +: AW]   = d_pc[k];
    end
    model_step(en, rdy, clr);
  endtask

  task automatic rand_data();
    for (int k = 0; k < NS; k++) begin
      d_tag[k] = RW'($urandom);
      d_val[k] = $urandom;
      d_pc[k]  = AW'($urandom);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b1, 1'b0);
  endtask

  // Monitor: every broadcast must match the oldest prediction, in its cycle;
  // between broadcasts the payload must hold the last predicted one.
  initial begin : monitor
    entry_t e;
    forever begin
      @(negedge clk_in);
      if (rst_in === 1'b1) begin
        if (bus.CDB_en === 1'b1) begin
          vectors++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL cdb_unexpected cyc %0d got tag %0h src %0d want no broadcast",
                     cyc, bus.CDB_ROB_index, bus.CDB_src);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || bus.CDB_src !== e.src || bus.CDB_ROB_index !== e.tag ||
                bus.CDB_value !== e.val || bus.CDB_next_pc !== e.pc) begin
              errors++;
              $display("FAIL cdb_bcast cyc %0d got src %0d tag %0h val %h pc %h want src %0d tag %0h val %h pc %h cyc %0d",
                       cyc, bus.CDB_src, bus.CDB_ROB_index, bus.CDB_value, bus.CDB_next_pc,
                       e.src, e.tag, e.val, e.pc, e.cyc);
            end
            last_exp = e;
          end
        end else begin
          vectors++;
          if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            errors++;
            $display("FAIL cdb_missing cyc %0d got CDB_en %b want tag %0h src %0d",
                     cyc, bus.CDB_en, e.tag, e.src);
          end
          if (bus.CDB_en !== 1'b0 || bus.CDB_src !== last_exp.src ||
              bus.CDB_ROB_index !== last_exp.tag || bus.CDB_value !== last_exp.val ||
              bus.CDB_next_pc !== last_exp.pc) begin
            errors++;
            $display("FAIL cdb_hold cyc %0d got en %b tag %0h val %h pc %h src %0d want en 0 tag %0h val %h pc %h src %0d",
                     cyc, bus.CDB_en, bus.CDB_ROB_index, bus.CDB_value, bus.CDB_next_pc, bus.CDB_src,
                     last_exp.tag, last_exp.val, last_exp.pc, last_exp.src);
          end
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_en"},    64'(bus.CDB_en),        64'd0);
    chk({tag, "_tag"},   64'(bus.CDB_ROB_index), 64'd0);
    chk({tag, "_val"},   64'(bus.CDB_value),     64'd0);
    chk({tag, "_pc"},    64'(bus.CDB_next_pc),   64'd0);
    chk({tag, "_src"},   64'(bus.CDB_src),       64'd0);
    chk({tag, "_ready"}, 64'(bus.src_ready),     64'((1 << NS) - 1));
  endtask

  initial begin : driver
    rst_in   = 1'b0;
    rdy_in   = 1'b0;
    clear_in = 1'b0;
    bus.src_en        = '0;
    bus.src_ROB_index = '0;
    bus.src_value     = '0;
    bus.src_next_pc   = '0;
    for (int k = 0; k < NS; k++) begin
      d_tag[k] = '0;
      d_val[k] = '0;
      d_pc[k]  = '0;
    end

    @(negedge clk_in);
    check_reset_values("reset");
    rst_in = 1'b1;

    // Single entry on source 1.
    d_tag[1] = 4'd5;
    d_val[1] = 32'hDEADBEEF;
    d_pc[1]  = 32'h0000_1004;
    step(2'b10, 1'b1, 1'b0);
    idle(4);

    // Contention, twice, so the second pair starts at source 0 again.
    d_tag[0] = 4'd1; d_tag[1] = 4'd2;
    step(2'b11, 1'b1, 1'b0);
    idle(3);
    d_tag[0] = 4'd3; d_tag[1] = 4'd4;
    step(2'b11, 1'b1, 1'b0);
    idle(4);

    // Both sources streaming until source 0 fills and drops input.
    for (int i = 0; i < 10; i++) begin
      rand_data();
      d_tag[0] = RW'(i);
      step(2'b11, 1'b1, 1'b0);
    end
    idle(20);

    // Flush with entries buffered.
    for (int i = 0; i < 3; i++) begin
      rand_data();
      step(2'b11, 1'b1, 1'b0);
    end
    step('0, 1'b1, 1'b1);
    idle(6);

    // Pause with two entries buffered.
    rand_data();
    step(2'b11, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rand_data();
      step(2'b11, 1'b0, 1'b0);
    end
    idle(6);

    // Randomized traffic with occasional pauses and flushes.
    for (int i = 0; i < 400; i++) begin
      rand_data();
      step(NS'($urandom), ($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0));
    end
    idle(20);

    // Asynchronous reset between edges with entries buffered.
    for (int i = 0; i < 4; i++) begin
      rand_data();
      step(2'b11, 1'b1, 1'b0);
    end
    @(negedge clk_in);
    bus.src_en = '0;
    #2 rst_in = 1'b0;
    #1 check_reset_values("async_reset");
    for (int k = 0; k < NS; k++) mq[k].delete();
    exp_q.delete();
    rr       = 0;
    last_exp = '0;
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    idle(10);

    // Traffic after reset release.
    for (int i = 0; i < 40; i++) begin
      rand_data();
      step(NS'($urandom), 1'b1, 1'b0);
    end
    idle(20);

    @(negedge clk_in);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
